// File: rtl/cc_speedcounter_if.sv
// cc_speedcounter_if
//   Bundles the control inputs and count/status outputs of the speed-timebase
//   counter. Signal names follow the board-level port names.
//   master : drives start/pause/levelup/clear, observes data/level/running/tick
//   slave  : the counter side
interface cc_speedcounter_if #(
    parameter int DW = 23,
    parameter int LW = 3
);
    logic          CC_SPEEDCOUNTER_start_InLow;
    logic          CC_SPEEDCOUNTER_pause_InLow;
    logic          CC_SPEEDCOUNTER_levelup_InLow;
    logic          CC_SPEEDCOUNTER_clear_InLow;
    logic [DW-1:0] CC_SPEEDCOUNTER_data_OutBUS;
    logic [LW-1:0] CC_SPEEDCOUNTER_level_OutBUS;
    logic          CC_SPEEDCOUNTER_running_OutHigh;
    logic          CC_SPEEDCOUNTER_tick_OutHigh;

    modport master (
        output CC_SPEEDCOUNTER_start_InLow,
        output CC_SPEEDCOUNTER_pause_InLow,
        output CC_SPEEDCOUNTER_levelup_InLow,
        output CC_SPEEDCOUNTER_clear_InLow,
        input  CC_SPEEDCOUNTER_data_OutBUS,
        input  CC_SPEEDCOUNTER_level_OutBUS,
        input  CC_SPEEDCOUNTER_running_OutHigh,
        input  CC_SPEEDCOUNTER_tick_OutHigh
    );

    modport slave (
        input  CC_SPEEDCOUNTER_start_InLow,
        input  CC_SPEEDCOUNTER_pause_InLow,
        input  CC_SPEEDCOUNTER_levelup_InLow,
        input  CC_SPEEDCOUNTER_clear_InLow,
        output CC_SPEEDCOUNTER_data_OutBUS,
        output CC_SPEEDCOUNTER_level_OutBUS,
        output CC_SPEEDCOUNTER_running_OutHigh,
        output CC_SPEEDCOUNTER_tick_OutHigh
    );
endinterface

// File: rtl/cc_speedcounter.sv
// cc_speedcounter
//   Speed-timebase counter feeding the speed comparator. The count advances
//   once per prescaler strobe; the strobe period shrinks as the speed level
//   rises. A low on clear (comparator T0 output) zeroes the count and emits a
//   one-cycle game tick.
// Ports
//   CC_SPEEDCOUNTER_CLOCK_50    system clock, rising edge
//   CC_SPEEDCOUNTER_RESET_InLow asynchronous reset, active-low
//   bus (slave)                 start/pause/levelup/clear in (active-low),
//                               data/level/running/tick out (registered)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset; count and prescaler held at 0, wait for start
// S_RUN   | prescaler running, count advances, clear honoured
// S_PAUSE | count and prescaler frozen, clear ignored
module cc_speedcounter #(
    parameter int SPEEDCOUNTER_DATAWIDTH  = 23,
    parameter int SPEEDCOUNTER_LEVELWIDTH = 3,
    parameter int SPEEDCOUNTER_PRESCALE   = 4
) (
    input  logic             CC_SPEEDCOUNTER_CLOCK_50,
    input  logic             CC_SPEEDCOUNTER_RESET_InLow,
    cc_speedcounter_if.slave bus
);
    localparam int DW      = SPEEDCOUNTER_DATAWIDTH;
    localparam int LW      = SPEEDCOUNTER_LEVELWIDTH;
    localparam int MAX_DIV = SPEEDCOUNTER_PRESCALE * (2 ** LW);
    localparam int PW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam logic [LW-1:0] LEVEL_MAX = {LW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [LW-1:0] level_q, level_d;
    logic          tick_q, tick_d;
    logic          running_q, running_d;
    logic [31:0]   div_m1;
    logic          strobe;

    // Terminal value shrinks with level. Using >= means a level raised
    // mid-period strobes on the very next edge rather than wrapping.
    always_comb begin
        div_m1 = 32'(SPEEDCOUNTER_PRESCALE) * (32'(2 ** LW) - 32'(level_q)) - 32'd1;
        strobe = (32'(presc_q) >= div_m1);
    end

    always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50 or negedge CC_SPEEDCOUNTER_RESET_InLow) begin
        if (!CC_SPEEDCOUNTER_RESET_InLow) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!bus.CC_SPEEDCOUNTER_start_InLow) state_d = S_RUN;
            S_RUN:   if (!bus.CC_SPEEDCOUNTER_pause_InLow) state_d = S_PAUSE;
            S_PAUSE: if (bus.CC_SPEEDCOUNTER_pause_InLow)  state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath acts on the current state, so a clear held through the
    // PAUSE->RUN edge takes effect on the first edge spent in RUN.
    always_comb begin
        count_d   = count_q;
        presc_d   = presc_q;
        level_d   = level_q;
        tick_d    = 1'b0;
        running_d = (state_d == S_RUN);
        case (state_q)
            S_IDLE: begin
                count_d = '0;
                presc_d = '0;
            end
            S_RUN: begin
                if (!bus.CC_SPEEDCOUNTER_clear_InLow) begin
                    count_d = '0;
                    presc_d = '0;
                    tick_d  = 1'b1;
                end else if (strobe) begin
                    presc_d = '0;
                    count_d = count_q + DW'(1);
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: ;
        endcase
        if (!bus.CC_SPEEDCOUNTER_levelup_InLow && (level_q != LEVEL_MAX)) begin
            level_d = level_q + LW'(1);
        end
    end

    always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50 or negedge CC_SPEEDCOUNTER_RESET_InLow) begin
        if (!CC_SPEEDCOUNTER_RESET_InLow) begin
            count_q   <= '0;
            presc_q   <= '0;
            level_q   <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            presc_q   <= presc_d;
            level_q   <= level_d;
            tick_q    <= tick_d;
            running_q <= running_d;
        end
    end

    assign bus.CC_SPEEDCOUNTER_data_OutBUS     = count_q;
    assign bus.CC_SPEEDCOUNTER_level_OutBUS    = level_q;
    assign bus.CC_SPEEDCOUNTER_running_OutHigh = running_q;
    assign bus.CC_SPEEDCOUNTER_tick_OutHigh    = tick_q;
endmodule

// File: tb/tb_cc_speedcounter.sv
// tb_cc_speedcounter
//   Drives a default-width counter and a 4-bit-wide counter from the same
//   control inputs and compares both against a cycle reference model that
//   tracks the count as an unbounded integer (wrapping falls out of masking).
module tb_cc_speedcounter;
    localparam int DW  = 23;
    localparam int DW4 = 4;
    localparam int LW  = 3;
    localparam int PS  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start_n = 1'b1, pause_n = 1'b1, levelup_n = 1'b1, clear_n = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cc_speedcounter_if #(.DW(DW),  .LW(LW)) bus ();
    cc_speedcounter_if #(.DW(DW4), .LW(LW)) bus4 ();

    assign bus.CC_SPEEDCOUNTER_start_InLow    = start_n;
    assign bus.CC_SPEEDCOUNTER_pause_InLow    = pause_n;
    assign bus.CC_SPEEDCOUNTER_levelup_InLow  = levelup_n;
    assign bus.CC_SPEEDCOUNTER_clear_InLow    = clear_n;
    assign bus4.CC_SPEEDCOUNTER_start_InLow   = start_n;
    assign bus4.CC_SPEEDCOUNTER_pause_InLow   = pause_n;
    assign bus4.CC_SPEEDCOUNTER_levelup_InLow = levelup_n;
    assign bus4.CC_SPEEDCOUNTER_clear_InLow   = clear_n;

    cc_speedcounter #(
        .SPEEDCOUNTER_DATAWIDTH (DW),
        .SPEEDCOUNTER_LEVELWIDTH(LW),
        .SPEEDCOUNTER_PRESCALE  (PS)
    ) u_dut (
        .CC_SPEEDCOUNTER_CLOCK_50   (clk),
        .CC_SPEEDCOUNTER_RESET_InLow(rst_n),
        .bus                        (bus)
    );

    cc_speedcounter #(
        .SPEEDCOUNTER_DATAWIDTH (DW4),
        .SPEEDCOUNTER_LEVELWIDTH(LW),
        .SPEEDCOUNTER_PRESCALE  (PS)
    ) u_dut4 (
        .CC_SPEEDCOUNTER_CLOCK_50   (clk),
        .CC_SPEEDCOUNTER_RESET_InLow(rst_n),
        .bus                        (bus4)
    );

    wire [36:0] obs = {bus.CC_SPEEDCOUNTER_data_OutBUS, bus4.CC_SPEEDCOUNTER_data_OutBUS,
                       bus.CC_SPEEDCOUNTER_level_OutBUS, bus.CC_SPEEDCOUNTER_running_OutHigh,
                       bus.CC_SPEEDCOUNTER_tick_OutHigh, bus4.CC_SPEEDCOUNTER_level_OutBUS,
                       bus4.CC_SPEEDCOUNTER_running_OutHigh, bus4.CC_SPEEDCOUNTER_tick_OutHigh};

    // Reference model: started/paused flags, phase within the current
    // count period, unbounded count, level, tick.
    bit     m_started, m_paused, m_tick;
    int     m_phase, m_level;
    longint m_count;

    function automatic int divisor(input int lvl);
        return PS * ((1 << LW) - lvl);
    endfunction

    function automatic void model_reset();
        m_started = 1'b0; m_paused = 1'b0; m_tick = 1'b0;
        m_phase = 0; m_level = 0; m_count = 0;
    endfunction

    function automatic logic [36:0] expv();
        logic [63:0] c = 64'(m_count);
        logic        r = m_started && !m_paused;
        return {c[DW-1:0], c[DW4-1:0], 3'(m_level), r, m_tick, 3'(m_level), r, m_tick};
    endfunction

    task automatic step();
        int lvl;
        @(posedge clk);
        lvl = m_level;
        if (!m_started) begin
            m_count = 0; m_phase = 0; m_tick = 1'b0;
            if (!start_n) m_started = 1'b1;
        end else if (m_paused) begin
            m_tick = 1'b0;
            if (pause_n) m_paused = 1'b0;
        end else begin
            if (!clear_n) begin
                m_count = 0; m_phase = 0; m_tick = 1'b1;
            end else begin
                m_tick = 1'b0;
                m_phase++;
                if (m_phase >= divisor(lvl)) begin
                    m_phase = 0;
                    m_count++;
                end
            end
            if (!pause_n) m_paused = 1'b1;
        end
        if (!levelup_n && m_level < (1 << LW) - 1) m_level++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        n_vec++;
        if (obs !== 37'd0) begin
            n_err++; $display("FAIL reset_state got=%h want=0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            n_vec++;
            if (obs !== expv()) begin
                n_err++; $display("FAIL idle_hold cyc=%0d got=%h want=%h", i, obs, expv());
            end
        end
    endtask

    task automatic test_start();
        start_n = 1'b0;
        step();
        start_n = 1'b1;
        n_vec++;
        if (bus.CC_SPEEDCOUNTER_running_OutHigh !== 1'b1 || obs !== expv()) begin
            n_err++; $display("FAIL start_running got=%h want=%h", obs, expv());
        end
        for (int i = 1; i <= 96; i++) begin
            step();
            n_vec++;
            if (obs !== expv()) begin
                n_err++; $display("FAIL level0_count cyc=%0d got=%h want=%h", i, obs, expv());
            end
            if (i == 32 || i == 96) begin
                n_vec++;
                if (bus.CC_SPEEDCOUNTER_data_OutBUS !== 23'(i / 32)) begin
                    n_err++; $display("FAIL level0_period cyc=%0d got=%0d want=%0d", i,
                                      bus.CC_SPEEDCOUNTER_data_OutBUS, i / 32);
                end
            end
        end
    endtask

    task automatic test_levelup();
        for (int i = 0; i < 9; i++) begin
            levelup_n = 1'b0;
            step();
            levelup_n = 1'b1;
            step();
            n_vec++;
            if (obs !== expv()) begin
                n_err++; $display("FAIL levelup pulse=%0d got=%h want=%h", i, obs, expv());
            end
        end
        n_vec++;
        if (bus.CC_SPEEDCOUNTER_level_OutBUS !== 3'd7) begin
            n_err++; $display("FAIL level_saturate got=%0d want=7", bus.CC_SPEEDCOUNTER_level_OutBUS);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            n_vec++;
            if (obs !== expv()) begin
                n_err++; $display("FAIL level7_count cyc=%0d got=%h want=%h", i, obs, expv());
            end
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 10000 && bus.CC_SPEEDCOUNTER_data_OutBUS != 23'd2047; i++) begin
            step();
            n_vec++;
            if (obs !== expv()) begin
                n_err++; $display("FAIL run_to_2047 cyc=%0d got=%h want=%h", i, obs, expv());
            end
        end
        n_vec++;
        if (bus.CC_SPEEDCOUNTER_data_OutBUS !== 23'd2047) begin
            n_err++; $display("FAIL reach_2047 timeout got=%0d want=2047", bus.CC_SPEEDCOUNTER_data_OutBUS);
        end
        for (int i = 0; i < 8 && bus.CC_SPEEDCOUNTER_data_OutBUS == 23'd2047; i++) step();
        n_vec++;
        if (bus.CC_SPEEDCOUNTER_data_OutBUS !== 23'd2048 || bus.CC_SPEEDCOUNTER_tick_OutHigh !== 1'b0) begin
            n_err++; $display("FAIL no_clear_2048 got=%0d tick=%b want=2048 tick=0",
                              bus.CC_SPEEDCOUNTER_data_OutBUS, bus.CC_SPEEDCOUNTER_tick_OutHigh);
        end
        step();
        clear_n = 1'b0;
        step();
        clear_n = 1'b1;
        n_vec++;
        if (bus.CC_SPEEDCOUNTER_data_OutBUS !== 23'd0 || bus.CC_SPEEDCOUNTER_tick_OutHigh !== 1'b1
            || obs !== expv()) begin
            n_err++; $display("FAIL clear_tick got=%h want=%h", obs, expv());
        end
        step();
        n_vec++;
        if (bus.CC_SPEEDCOUNTER_tick_OutHigh !== 1'b0 || obs !== expv()) begin
            n_err++; $display("FAIL tick_one_cycle got=%h want=%h", obs, expv());
        end
        for (int i = 0; i < 40 && m_phase != divisor(m_level) - 1; i++) step();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 40 && m_phase != divisor(m_level) - 1; j++) step();
            step();
        end
        for (int i = 0; i < 40 && m_phase != divisor(m_level) - 1; i++) step();
        clear_n = 1'b0;
        step();
        clear_n = 1'b1;
        n_vec++;
        if (bus.CC_SPEEDCOUNTER_data_OutBUS !== 23'd0 || obs !== expv()) begin
            n_err++; $display("FAIL clear_vs_strobe got=%h want=%h", obs, expv());
        end
    endtask

    task automatic test_pause();
        logic [DW-1:0] frozen;
        for (int i = 0; i < 7; i++) step();
        pause_n = 1'b0;
        step();
        frozen = bus.CC_SPEEDCOUNTER_data_OutBUS;
        for (int i = 0; i < 50; i++) begin
            step();
            n_vec++;
            if (bus.CC_SPEEDCOUNTER_data_OutBUS !== frozen || obs !== expv()) begin
                n_err++; $display("FAIL pause_hold cyc=%0d got=%h want=%h", i, obs, expv());
            end
        end
        pause_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            n_vec++;
            if (obs !== expv()) begin
                n_err++; $display("FAIL pause_resume cyc=%0d got=%h want=%h", i, obs, expv());
            end
        end
    endtask

    task automatic test_pause_clear();
        pause_n = 1'b0;
        for (int i = 0; i < 3; i++) step();
        clear_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (bus.CC_SPEEDCOUNTER_tick_OutHigh !== 1'b0 || obs !== expv()) begin
                n_err++; $display("FAIL clear_in_pause cyc=%0d got=%h want=%h", i, obs, expv());
            end
        end
        pause_n = 1'b1;
        step();
        n_vec++;
        if (bus.CC_SPEEDCOUNTER_tick_OutHigh !== 1'b0 || obs !== expv()) begin
            n_err++; $display("FAIL pause_exit_edge got=%h want=%h", obs, expv());
        end
        step();
        clear_n = 1'b1;
        n_vec++;
        if (bus.CC_SPEEDCOUNTER_tick_OutHigh !== 1'b1 || bus.CC_SPEEDCOUNTER_data_OutBUS !== 23'd0
            || obs !== expv()) begin
            n_err++; $display("FAIL pending_clear got=%h want=%h", obs, expv());
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 200 && bus4.CC_SPEEDCOUNTER_data_OutBUS != 4'd15; i++) step();
        for (int i = 0; i < 8 && bus4.CC_SPEEDCOUNTER_data_OutBUS == 4'd15; i++) step();
        n_vec++;
        if (bus4.CC_SPEEDCOUNTER_data_OutBUS !== 4'd0 || bus4.CC_SPEEDCOUNTER_tick_OutHigh !== 1'b0
            || obs !== expv()) begin
            n_err++; $display("FAIL wrap4 got=%h want=%h", obs, expv());
        end
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 5; i++) step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (obs !== 37'd0) begin
            n_err++; $display("FAIL async_reset got=%h want=0", obs);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_vec++;
            if (bus.CC_SPEEDCOUNTER_running_OutHigh !== 1'b0 || obs !== expv()) begin
                n_err++; $display("FAIL restart_needs_start cyc=%0d got=%h want=%h", i, obs, expv());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            start_n   = ($urandom_range(0, 29) != 0);
            clear_n   = ($urandom_range(0, 39) != 0);
            levelup_n = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 19) == 0) pause_n = ~pause_n;
            step();
            n_vec++;
            if (obs !== expv()) begin
                n_err++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, expv());
            end
        end
        start_n = 1'b1; clear_n = 1'b1; levelup_n = 1'b1; pause_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_start();
        test_levelup();
        test_clear();
        test_pause();
        test_pause_clear();
        test_wrap();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
